alu_entry_sequencer: RTL
========================

// Module: alu_entry_sequencer
// PURPOSE
//   Parametrised operand-entry controller for the board-level ALU datapath. It replaces the
//   three-button direct-load scheme: a single ENTER button steps an FSM through A, B, OP and EXEC.
//   It debounces all buttons and keeps a circular history of the last HIST_DEPTH results.
//   It sits between the board I/O (switches, buttons) and the combinational ALU and display controller.
// PARAMETERS
//   DATA_WIDTH       8          operand/result width
//   OP_WIDTH         6          ALU opcode width, taken from sw_in[OP_WIDTH-1:0]; must be <= DATA_WIDTH
//   DEBOUNCE_CYCLES  1000000    consecutive stable-high clocks before a button counts as pressed (>=2)
//   HIST_DEPTH       4          result history entries; power of two, >=2
// PORTS
//   clk           in   1                        system clock (100 MHz on board)
//   reset_n       in   1                        reset; synchronous, active-low
//   sw_in         in   DATA_WIDTH               switch value for operand/opcode entry
//   btn_enter     in   1                        raw (bouncy) advance button
//   btn_back      in   1                        raw step-back button
//   btn_hist      in   1                        raw history-browse button
//   alu_a         out  DATA_WIDTH               registered operand A to ALU
//   alu_b         out  DATA_WIDTH               registered operand B to ALU
//   alu_op        out  OP_WIDTH                 registered opcode to ALU
//   alu_result    in   DATA_WIDTH               combinational ALU result
//   alu_overflow  in   1                        ALU overflow flag
//   alu_zero      in   1                        ALU zero flag
//   disp_value    out  DATA_WIDTH               value for display controller / LEDs
//   disp_ovf      out  1                        overflow flag of displayed history entry (0 outside S_SHOW)
//   disp_zero     out  1                        zero flag of displayed history entry (0 outside S_SHOW)
//   state_o       out  3                        current FSM state encoding (for LEDs)
//   hist_idx      out  $clog2(HIST_DEPTH)       age of displayed entry (0 = newest)
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): state S_A, alu_a/alu_b/alu_op=0, history empty (count=0, wr_ptr=0),
//     hist_idx=0, debounce counters/levels=0, all pulses 0. Reset mid-entry or mid-EXEC discards everything.
//   Debounce, per button: counter increments while raw=1, clears when raw=0. Level goes 1 when
//     counter reaches DEBOUNCE_CYCLES; counter saturates there. Level goes 0 on first raw=0 clock.
//     One-clock pulse on rising edge of level. Holding a button yields exactly one pulse.
//   FSM encoding: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
//     S_A   : enter -> alu_a<=sw_in, go S_B.         back -> ignored.
//     S_B   : enter -> alu_b<=sw_in, go S_OP.        back -> go S_A (alu_a kept).
//     S_OP  : enter -> alu_op<=sw_in[OP_WIDTH-1:0], go S_EXEC.  back -> go S_B.
//     S_EXEC: unconditional, exactly 1 clock. Write {alu_overflow,alu_zero,alu_result} to hist[wr_ptr],
//             wr_ptr<=wr_ptr+1 (mod HIST_DEPTH), count<=min(count+1,HIST_DEPTH), hist_idx<=0, go S_SHOW.
//             Button pulses arriving in this clock are dropped.
//     S_SHOW: enter -> go S_A, hist_idx<=0.  back -> go S_OP, hist_idx<=0 (re-run with new opcode).
//             hist -> hist_idx<=(hist_idx+1==count)?0:hist_idx+1.
//   Simultaneous pulses: back beats enter; hist is acted on only in S_SHOW and only with no back/enter pulse.
//   Operands persist across runs until overwritten, so ENTER,ENTER,ENTER reruns with new values.
//   Latency: register load one clock after the enter pulse. Result in history and on disp_value
//     two clocks after the S_OP enter pulse (S_EXEC clock, then visible in S_SHOW).
//   disp_value: combinational sw_in in S_A/S_B/S_OP (live preview); 0 in S_EXEC;
//     hist[(wr_ptr-1-hist_idx) mod HIST_DEPTH] in S_SHOW.
//   History wrap: once count=HIST_DEPTH, the oldest entry is overwritten; count does not exceed HIST_DEPTH.
// TESTING  (DEBOUNCE_CYCLES=4, HIST_DEPTH=4, DATA_WIDTH=8)
//   1 Bounce: btn_enter 1,0,1,1,0 then held 1 for 10 clks -> exactly one pulse, 4 clks after stable
//     high; state S_A->S_B.
//   2 Entry: sw=0x05 enter, sw=0x03 enter, sw=0x20 enter (ADD); ALU returns 0x08 ->
//     alu_a=05, alu_b=03, alu_op=20; S_EXEC for 1 clk; S_SHOW with disp_value=08, disp_zero=0.
//   3 Back: in S_OP press back, then back -> S_B then S_A; alu_a unchanged; back in S_A -> no change.
//   4 History wrap: 5 runs with results 01..05 -> count=4; hist presses show 05,04,03,02, then 05 (idx wraps 3->0).
//   5 Simultaneous: enter+back same clk in S_B -> S_A; hist in S_A -> hist_idx stays 0.
//   6 Reset mid-run: reset_n=0 during S_EXEC -> next clk S_A, history empty, alu_a/alu_b/alu_op=0.

Source files
------------

// File: rtl/alu_entry_sequencer_if.sv
// Board-side bundle for the ALU entry sequencer: switches, buttons, ALU operands/result and display.
// master = board/ALU side, slave = sequencer.
interface alu_entry_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6,
  parameter int HIST_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]         sw_in;
  logic                          btn_enter;
  logic                          btn_back;
  logic                          btn_hist;
  logic [DATA_WIDTH-1:0]         alu_a;
  logic [DATA_WIDTH-1:0]         alu_b;
  logic [OP_WIDTH-1:0]           alu_op;
  logic [DATA_WIDTH-1:0]         alu_result;
  logic                          alu_overflow;
  logic                          alu_zero;
  logic [DATA_WIDTH-1:0]         disp_value;
  logic                          disp_ovf;
  logic                          disp_zero;
  logic [2:0]                    state_o;
  logic [$clog2(HIST_DEPTH)-1:0] hist_idx;

  modport master (
    output sw_in, btn_enter, btn_back, btn_hist, alu_result, alu_overflow, alu_zero,
    input  alu_a, alu_b, alu_op, disp_value, disp_ovf, disp_zero, state_o, hist_idx
  );

  modport slave (
    input  sw_in, btn_enter, btn_back, btn_hist, alu_result, alu_overflow, alu_zero,
    output alu_a, alu_b, alu_op, disp_value, disp_ovf, disp_zero, state_o, hist_idx
  );
endinterface

// File: rtl/alu_entry_sequencer.sv
// Single-button operand entry (A -> B -> OP -> EXEC -> SHOW) for the board ALU, with button
// debouncing and a circular history of the last HIST_DEPTH results.
module alu_entry_sequencer #(
  parameter int DATA_WIDTH      = 8,
  parameter int OP_WIDTH        = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HIST_DEPTH      = 4
) (
  input logic                clk,
  input logic                reset_n,
  alu_entry_sequencer_if.slave bus
);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PTR_W  = $clog2(HIST_DEPTH);
  localparam int HCNT_W = PTR_W + 1;
  localparam int ENT_W  = DATA_WIDTH + 2;
  localparam logic [CNT_W-1:0]  DB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HCNT_W-1:0] HIST_MAX = HCNT_W'(HIST_DEPTH);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic [2:0]       w_raw;
  logic [CNT_W-1:0] r_db_cnt [3];
  logic [2:0]       r_db_lvl;
  logic [2:0]       r_pulse;
  logic             w_enter;
  logic             w_back;
  logic             w_hist;

  assign w_raw   = {bus.btn_hist, bus.btn_back, bus.btn_enter};
  assign w_enter = r_pulse[0];
  assign w_back  = r_pulse[1];
  assign w_hist  = r_pulse[2];

  // The pulse is raised on the same edge the level rises, so a held button fires once.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n || !w_raw[i]) begin
        r_db_cnt[i] <= '0;
        r_db_lvl[i] <= 1'b0;
        r_pulse[i]  <= 1'b0;
      end else if (r_db_cnt[i] == DB_MAX) begin
        r_pulse[i]  <= 1'b0;
      end else begin
        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        r_db_lvl[i] <= (r_db_cnt[i] == DB_MAX - 1'b1);
        r_pulse[i]  <= (r_db_cnt[i] == DB_MAX - 1'b1);
      end
    end
  end

  state_t              r_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [OP_WIDTH-1:0]   r_op;
  logic [ENT_W-1:0]      r_hist [HIST_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_hist_idx;
  logic [HCNT_W-1:0]     r_count;
  logic [HCNT_W-1:0]     w_idx_inc;

  assign w_idx_inc = HCNT_W'(r_hist_idx) + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_A;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_wr_ptr   <= '0;
      r_hist_idx <= '0;
      r_count    <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        S_A: begin
          if (!w_back && w_enter) begin
            r_a     <= bus.sw_in;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (w_back) begin
            r_state <= S_A;
          end else if (w_enter) begin
            r_b     <= bus.sw_in;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (w_back) begin
            r_state <= S_B;
          end else if (w_enter) begin
            r_op    <= bus.sw_in[OP_WIDTH-1:0];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_hist[r_wr_ptr] <= {bus.alu_overflow, bus.alu_zero, bus.alu_result};
          r_wr_ptr         <= r_wr_ptr + 1'b1;
          if (r_count != HIST_MAX) r_count <= r_count + 1'b1;
          r_hist_idx       <= '0;
          r_state          <= S_SHOW;
        end
        S_SHOW: begin
          if (w_back) begin
            r_hist_idx <= '0;
            r_state    <= S_OP;
          end else if (w_enter) begin
            r_hist_idx <= '0;
            r_state    <= S_A;
          end else if (w_hist) begin
            r_hist_idx <= (w_idx_inc == r_count) ? '0 : r_hist_idx + 1'b1;
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  logic [PTR_W-1:0] w_rd_ptr;
  logic [ENT_W-1:0] w_rd_ent;

  // Newest entry sits just behind the write pointer; hist_idx counts back from there.
  assign w_rd_ptr = r_wr_ptr - PTR_W'(1) - r_hist_idx;
  assign w_rd_ent = r_hist[w_rd_ptr];

  always_comb begin
    bus.disp_value = bus.sw_in;
    bus.disp_ovf   = 1'b0;
    bus.disp_zero  = 1'b0;
    case (r_state)
      S_EXEC: bus.disp_value = '0;
      S_SHOW: begin
        bus.disp_value = w_rd_ent[DATA_WIDTH-1:0];
        bus.disp_zero  = w_rd_ent[DATA_WIDTH];
        bus.disp_ovf   = w_rd_ent[DATA_WIDTH+1];
      end
      default: ;
    endcase
  end

  assign bus.alu_a    = r_a;
  assign bus.alu_b    = r_b;
  assign bus.alu_op   = r_op;
  assign bus.state_o  = r_state;
  assign bus.hist_idx = r_hist_idx;
endmodule
